// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial ripple adder. One full-adder bit is computed per
//             clock, LSB first, so a WIDTH-bit add takes WIDTH cycles in RUN
//             followed by a single DONE cycle.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH      operand/result width in bits (2..32)
//  Ports
//    clk        rising-edge clock
//    rst_n      synchronous active-low reset
//    start      request pulse, honoured only while idle
//    a, b       operands, captured when start is accepted
//    carry_in   initial carry, captured when start is accepted
//    busy       high while an operation is in RUN or DONE
//    done       one-cycle pulse when the result becomes valid
//    sum        registered result, held until the next accepted start
//    carry_out  registered final carry, same validity as sum
//    overflow   signed overflow flag (only with SERIAL_ADDER_OVF_EN)
//  Configuration
//    SERIAL_ADDER_OVF_EN  define to add the overflow port and its logic
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             carry_out,
    output logic             overflow
`else
    output logic             carry_out
`endif
);

    localparam int          C_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [WIDTH-1:0]   r_a_q,     w_a_d;
    logic [WIDTH-1:0]   r_b_q,     w_b_d;
    logic [WIDTH-1:0]   r_res_q,   w_res_d;
    logic [WIDTH-1:0]   r_sum_q,   w_sum_d;
    logic [C_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic               r_carry_q, w_carry_d;
    logic               r_cout_q,  w_cout_d;

    // Full-adder slice working on the current LSBs of the shift registers.
    logic w_bit;
    logic w_bit_carry;
    assign w_bit       = r_a_q[0] ^ r_b_q[0] ^ r_carry_q;
    assign w_bit_carry = (r_a_q[0] & r_b_q[0]) | (r_carry_q & (r_a_q[0] ^ r_b_q[0]));

`ifdef SERIAL_ADDER_OVF_EN
    // The operand MSBs are shifted out during RUN, so they are kept aside
    // at acceptance for the overflow decision.
    logic r_amsb_q, w_amsb_d;
    logic r_bmsb_q, w_bmsb_d;
    logic r_ovf_q,  w_ovf_d;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_a_d     = r_a_q;
        w_b_d     = r_b_q;
        w_res_d   = r_res_q;
        w_sum_d   = r_sum_q;
        w_cnt_d   = r_cnt_q;
        w_carry_d = r_carry_q;
        w_cout_d  = r_cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        w_amsb_d  = r_amsb_q;
        w_bmsb_d  = r_bmsb_q;
        w_ovf_d   = r_ovf_q;
`endif
        case (r_state_q)
            IDLE: begin
                if (start) begin
                    w_state_d = RUN;
                    w_a_d     = a;
                    w_b_d     = b;
                    w_carry_d = carry_in;
                    w_cnt_d   = '0;
`ifdef SERIAL_ADDER_OVF_EN
                    w_amsb_d  = a[WIDTH-1];
                    w_bmsb_d  = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                // Sum bits enter at the MSB end so that after WIDTH shifts
                // the first (LSB) bit has arrived at position 0.
                w_res_d   = {w_bit, r_res_q[WIDTH-1:1]};
                w_a_d     = r_a_q >> 1;
                w_b_d     = r_b_q >> 1;
                w_carry_d = w_bit_carry;
                w_cnt_d   = r_cnt_q + 1'b1;
                if (r_cnt_q == C_LAST) begin
                    w_state_d = DONE;
                    w_sum_d   = w_res_d;
                    w_cout_d  = w_bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // The bit produced on this final cycle is the sum MSB.
                    w_ovf_d   = (r_amsb_q == r_bmsb_q) && (w_bit != r_amsb_q);
`endif
                end
            end
            DONE: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q <= IDLE;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_res_q   <= '0;
            r_sum_q   <= '0;
            r_cnt_q   <= '0;
            r_carry_q <= 1'b0;
            r_cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_amsb_q  <= 1'b0;
            r_bmsb_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_res_q   <= w_res_d;
            r_sum_q   <= w_sum_d;
            r_cnt_q   <= w_cnt_d;
            r_carry_q <= w_carry_d;
            r_cout_q  <= w_cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            r_amsb_q  <= w_amsb_d;
            r_bmsb_q  <= w_bmsb_d;
            r_ovf_q   <= w_ovf_d;
`endif
        end
    end

    assign busy      = (r_state_q == RUN) || (r_state_q == DONE);
    assign done      = (r_state_q == DONE);
    assign sum       = r_sum_q;
    assign carry_out = r_cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign overflow  = r_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Self-checking bench for serial_adder (WIDTH=8). Results are
//             compared with an arithmetic reference (a+b+cin, signed range
//             test for overflow).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             carry_in = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic             overflow;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .carry_out (carry_out),
        .overflow  (overflow)
`else
        .carry_out (carry_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic.
    function automatic logic [8:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'(x) + int'(y) + int'(c);
        return s[8:0];
    endfunction

    function automatic logic ref_ovf(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    task automatic check_result(input string tag, input logic [7:0] x, input logic [7:0] y, input logic c);
        logic [8:0] e;
        e = ref_add(x, y, c);
        check({tag, "_sum"}, 32'(sum), 32'(e[7:0]));
        check({tag, "_cout"}, 32'(carry_out), 32'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(overflow), 32'(ref_ovf(x, y, c)));
`endif
    endtask

    // One operation with a one-cycle start. Operand inputs are scrambled
    // during RUN; inject_at>0 pulses a second start on that RUN cycle.
    task automatic run_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                          input logic c, input int inject_at);
        int cyc;
        int busy_cnt;
        a = x; b = y; carry_in = c; start = 1'b1;
        tick();
        check({tag, "_busy_accept"}, 32'(busy), 32'd1);
        busy_cnt = 1;
        cyc = 0;
        while (!done && cyc < 20) begin
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            carry_in = 1'($urandom);
            start = 1'b0;
            if (cyc + 1 == inject_at) begin
                a = 8'hAA; b = 8'h55; start = 1'b1;
            end
            tick();
            cyc++;
            if (busy) busy_cnt++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(WIDTH + 1));
        check_result(tag, x, y, c);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
        check({tag, "_hold"}, 32'(sum), 32'(ref_add(x, y, c) & 9'h0FF));
        // Stay idle a few cycles to confirm no queued request starts.
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_no_queue"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int cyc;
        int last_done;
        logic [7:0] ca [4];
        logic [7:0] cb [4];
        logic       cc [4];
        logic [7:0] xa, xb;
        logic       xc;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(overflow), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Directed cases
        run_op("d35_0a", 8'h35, 8'h0A, 1'b0, 0);
        run_op("dff_01", 8'hFF, 8'h01, 1'b1, 0);
        run_op("d7f_01", 8'h7F, 8'h01, 1'b0, 0);
        run_op("d10_20_inj", 8'h10, 8'h20, 1'b0, 3);

        // Reset during RUN
        a = 8'h12; b = 8'h34; carry_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(carry_out), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("midrst_ovf", 32'(overflow), 32'd0);
`endif
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) cyc++;
        end
        check("midrst_no_done", 32'(cyc), 32'd0);
        run_op("after_rst", 8'h01, 8'h01, 1'b0, 0);

        // Reset priority over start on the same edge
        rst_n = 1'b0; start = 1'b1; a = 8'h05; b = 8'h06;
        tick();
        check("rst_prio_busy", 32'(busy), 32'd0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        check("rst_prio_idle", 32'(busy), 32'd0);

        // Back-to-back with start held high: corners then random operands
        ca[0] = 8'hFF; cb[0] = 8'hFF; cc[0] = 1'b1;
        ca[1] = 8'h00; cb[1] = 8'h00; cc[1] = 1'b0;
        ca[2] = 8'h80; cb[2] = 8'h80; cc[2] = 1'b0;
        ca[3] = 8'h7F; cb[3] = 8'h00; cc[3] = 1'b1;
        last_done = 0;
        start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (k < 4) begin
                xa = ca[k]; xb = cb[k]; xc = cc[k];
            end else begin
                xa = 8'($urandom); xb = 8'($urandom); xc = 1'($urandom);
            end
            a = xa; b = xb; carry_in = xc;
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!done && cyc < 30);
            check("b2b_done_seen", 32'(done), 32'd1);
            if (k > 0) check("b2b_spacing", 32'(cycle - last_done), 32'(WIDTH + 2));
            last_done = cycle;
            check_result("b2b", xa, xb, xc);
        end
        start = 1'b0;
        tick(); tick();
        check("final_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
